// File: rtl/erb_pkg.sv
// ---------------------------------------------------------------------------
// erb_pkg
//
// Shared definitions for the bus-off recovery counter slice.
//   erb_state_t        : recovery FSM state encoding (IDLE, COUNT, DONE).
//                        The fourth code, 2'b11, is unused and is steered
//                        back to IDLE by the counter.
//   ERB_CAN_THRESHOLD  : number of 11-recessive-bit sequences that CAN
//                        requires before a bus-off node may rejoin the bus.
// ---------------------------------------------------------------------------
package erb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        COUNT = 2'b01,
        DONE  = 2'b10
    } erb_state_t;

    localparam int ERB_CAN_THRESHOLD = 128;

endpackage : erb_pkg

// File: rtl/erb_majority_voter.sv
// ---------------------------------------------------------------------------
// erb_majority_voter
//
// Bitwise two-out-of-three voter used by the recovery counter when its
// registers are triplicated.
//
// Parameters:
//   WIDTH     width of each replica word
// Ports:
//   copy_a    input, replica 0
//   copy_b    input, replica 1
//   copy_c    input, replica 2
//   voted     output, bitwise majority of the three replicas
//   mismatch  output, high when any replica differs from the others
// ---------------------------------------------------------------------------
module erb_majority_voter
    import erb_pkg::*;
#(
    parameter int WIDTH = 1
) (
    input  logic [WIDTH-1:0] copy_a,
    input  logic [WIDTH-1:0] copy_b,
    input  logic [WIDTH-1:0] copy_c,
    output logic [WIDTH-1:0] voted,
    output logic             mismatch
);

    // Each output bit follows whichever value at least two replicas agree on,
    // so one corrupted replica can never change the voted word.
    assign voted = (copy_a & copy_b) | (copy_a & copy_c) | (copy_b & copy_c);

    // If a and b agree and a and c agree, all three agree; anything else
    // means at least one replica has been disturbed.
    assign mismatch = (copy_a != copy_b) || (copy_a != copy_c);

endmodule : erb_majority_voter

// File: rtl/erb_recovery_counter.sv
// ---------------------------------------------------------------------------
// erb_recovery_counter
//
// Bus-off recovery counter for the CAN fault-confinement path. While the
// fault FSM keeps the node in bus-off (enable high), every rising edge of
// the MAC's "eleven recessive bits received" level is counted. Reaching
// THRESHOLD raises erb_done (level) and erb_reached (one-cycle pulse); the
// count then saturates until clear restarts it or enable drops.
//
// Build option:
//   ERB_RECOVERY_TMR_EN  when defined, state, edge register and count are
//                        triplicated and every update is computed from the
//                        majority-voted value, so a single upset is scrubbed
//                        on the next edge and reported on tmr_error. When
//                        undefined, one copy of each register is kept and
//                        tmr_error is tied low. Ports are identical.
//
// Parameters:
//   THRESHOLD    rising edges needed to complete recovery (1..65535)
//   CW           count width, derived from THRESHOLD
// Ports:
//   clock        system clock, all logic on the rising edge
//   reset        synchronous, active-high reset
//   enable       node is in bus-off, counting permitted
//   clear        restart the count from zero
//   elevrecb     eleven recessive bits seen (level, may stay high)
//   erb_count    current count, 0..THRESHOLD
//   erb_done     high while the count sits at THRESHOLD
//   erb_reached  one-cycle pulse on entry to DONE
//   tmr_error    replica disagreement seen in the previous cycle
// ---------------------------------------------------------------------------
module erb_recovery_counter
    import erb_pkg::*;
#(
    parameter  int THRESHOLD = ERB_CAN_THRESHOLD,
    localparam int CW        = $clog2(THRESHOLD + 1)
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          enable,
    input  logic          clear,
    input  logic          elevrecb,
    output logic [CW-1:0] erb_count,
    output logic          erb_done,
    output logic          erb_reached,
    output logic          tmr_error
);

`ifdef ERB_RECOVERY_TMR_EN
    localparam int REP = 3;
`else
    localparam int REP = 1;
`endif

    // Register replicas (a single copy in the default build).
    erb_state_t    state_r [REP];
    logic [REP-1:0] edged_r;
    logic [CW-1:0] count_r [REP];
    logic          reached_r;

    // Values every update is computed from: the voted word in the TMR build,
    // the lone register otherwise.
    erb_state_t    state_v;
    logic          edged_v;
    logic [CW-1:0] count_v;

    logic          inc_event;
    logic          last_step;
    logic          hit;

`ifdef ERB_RECOVERY_TMR_EN
    logic [1:0] state_vote;
    logic       state_mm;
    logic       edged_mm;
    logic       count_mm;
    logic       tmr_error_r;

    erb_majority_voter #(.WIDTH(2)) u_state_voter (
        .copy_a   (state_r[0]),
        .copy_b   (state_r[1]),
        .copy_c   (state_r[2]),
        .voted    (state_vote),
        .mismatch (state_mm)
    );

    erb_majority_voter #(.WIDTH(1)) u_edged_voter (
        .copy_a   (edged_r[0]),
        .copy_b   (edged_r[1]),
        .copy_c   (edged_r[2]),
        .voted    (edged_v),
        .mismatch (edged_mm)
    );

    erb_majority_voter #(.WIDTH(CW)) u_count_voter (
        .copy_a   (count_r[0]),
        .copy_b   (count_r[1]),
        .copy_c   (count_r[2]),
        .voted    (count_v),
        .mismatch (count_mm)
    );

    assign state_v = erb_state_t'(state_vote);

    // The error flag is registered so it never forms a path from the
    // replicas straight to a port, and it lasts exactly one cycle per upset
    // because the upset is scrubbed on the same edge that sets the flag.
    always_ff @(posedge clock) begin
        if (reset) begin
            tmr_error_r <= 1'b0;
        end else begin
            tmr_error_r <= state_mm | edged_mm | count_mm;
        end
    end

    assign tmr_error = tmr_error_r;
`else
    assign state_v   = state_r[0];
    assign edged_v   = edged_r[0];
    assign count_v   = count_r[0];
    assign tmr_error = 1'b0;
`endif

    // A count event is a rising edge of elevrecb. Because edged follows the
    // input in every state, a level that was already high when enable rose
    // never looks like an edge.
    assign inc_event = elevrecb & ~edged_v;
    assign last_step = (count_v == CW'(THRESHOLD - 1));

    // The increment that lands on THRESHOLD: only from COUNT, and only when
    // neither leaving bus-off nor clear takes priority over it.
    assign hit = (state_v == COUNT) & enable & ~clear & inc_event & last_step;

    // Recovery FSM and counter. Every replica is loaded from the voted
    // values in every branch, including the "hold" cases, so a corrupted
    // replica is overwritten on the next edge rather than kept.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int r = 0; r < REP; r++) begin
                state_r[r] <= IDLE;
                edged_r[r] <= 1'b0;
                count_r[r] <= '0;
            end
            reached_r <= 1'b0;
        end else begin
            reached_r <= hit;
            for (int r = 0; r < REP; r++) begin
                edged_r[r] <= elevrecb;
                case (state_v)
                    IDLE: begin
                        // An edge coinciding with enable's arrival is ignored.
                        count_r[r] <= '0;
                        state_r[r] <= enable ? COUNT : IDLE;
                    end
                    COUNT: begin
                        if (!enable) begin
                            state_r[r] <= IDLE;
                            count_r[r] <= '0;
                        end else if (clear) begin
                            state_r[r] <= COUNT;
                            count_r[r] <= '0;
                        end else if (inc_event) begin
                            state_r[r] <= last_step ? DONE : COUNT;
                            count_r[r] <= count_v + CW'(1);
                        end else begin
                            state_r[r] <= COUNT;
                            count_r[r] <= count_v;
                        end
                    end
                    DONE: begin
                        if (!enable) begin
                            state_r[r] <= IDLE;
                            count_r[r] <= '0;
                        end else if (clear) begin
                            state_r[r] <= COUNT;
                            count_r[r] <= '0;
                        end else begin
                            state_r[r] <= DONE;
                            count_r[r] <= count_v;
                        end
                    end
                    default: begin
                        // Unused encoding: fall back to a clean idle state.
                        state_r[r] <= IDLE;
                        count_r[r] <= '0;
                    end
                endcase
            end
        end
    end

    assign erb_count   = count_v;
    assign erb_done    = (state_v == DONE);
    assign erb_reached = reached_r;

endmodule : erb_recovery_counter

// File: tb/tb_erb_recovery_counter.sv
// ---------------------------------------------------------------------------
// tb_erb_recovery_counter
//
// Drives two counters (THRESHOLD=128 and THRESHOLD=4) with the same inputs
// and compares both against a behavioural model of the recovery rules.
// The TMR upset check is compiled in when ERB_RECOVERY_TMR_EN is defined.
// ---------------------------------------------------------------------------
module tb_erb_recovery_counter;

    logic       clock = 1'b0;
    logic       reset;
    logic       enable;
    logic       clear;
    logic       elevrecb;

    logic [7:0] count_a;
    logic       done_a;
    logic       reached_a;
    logic       tmr_a;

    logic [2:0] count_b;
    logic       done_b;
    logic       reached_b;
    logic       tmr_b;

    erb_recovery_counter #(.THRESHOLD(128)) dut (
        .clock       (clock),
        .reset       (reset),
        .enable      (enable),
        .clear       (clear),
        .elevrecb    (elevrecb),
        .erb_count   (count_a),
        .erb_done    (done_a),
        .erb_reached (reached_a),
        .tmr_error   (tmr_a)
    );

    erb_recovery_counter #(.THRESHOLD(4)) dut4 (
        .clock       (clock),
        .reset       (reset),
        .enable      (enable),
        .clear       (clear),
        .elevrecb    (elevrecb),
        .erb_count   (count_b),
        .erb_done    (done_b),
        .erb_reached (reached_b),
        .tmr_error   (tmr_b)
    );

    always #5 clock = ~clock;

    int total = 0;
    int bad   = 0;

    // Reference model: index 0 tracks THRESHOLD=128, index 1 THRESHOLD=4.
    // "in_busoff" means enable has been seen high for at least one edge.
    int m_th [2] = '{128, 4};
    int m_cnt [2];
    bit m_in [2];
    bit m_reached [2];
    bit m_prev;
    bit tmr_exp;

    typedef struct {
        bit rst;
        bit en;
        bit clr;
        bit lvl;
        int cnt;
        bit done;
        bit rch;
    } vec_t;

    vec_t vecs [$];

    // Advance the model by one clock edge with the inputs just applied.
    task automatic model_step(input bit r, input bit e, input bit c, input bit l);
        bit ev;
        ev = l & ~m_prev;
        for (int i = 0; i < 2; i++) begin
            m_reached[i] = 1'b0;
            if (r || !e) begin
                m_in[i]  = 1'b0;
                m_cnt[i] = 0;
            end else if (!m_in[i]) begin
                m_in[i]  = 1'b1;
                m_cnt[i] = 0;
            end else if (c) begin
                m_cnt[i] = 0;
            end else if (ev && m_cnt[i] < m_th[i]) begin
                m_cnt[i]     = m_cnt[i] + 1;
                m_reached[i] = (m_cnt[i] == m_th[i]);
            end
        end
        m_prev = r ? 1'b0 : l;
    endtask

    task automatic checkValue(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Apply one cycle of inputs, let the edge happen, then sample 1 time unit later.
    task automatic applyStimulus(input bit r, input bit e, input bit c, input bit l);
        reset    = r;
        enable   = e;
        clear    = c;
        elevrecb = l;
        @(posedge clock);
        model_step(r, e, c, l);
        #1;
    endtask

    task automatic checkOutput(input string tag);
        checkValue({tag, "_cnt128"}, count_a, m_cnt[0]);
        checkValue({tag, "_done128"}, done_a, (m_in[0] && m_cnt[0] == m_th[0]) ? 1 : 0);
        checkValue({tag, "_rch128"}, reached_a, m_reached[0]);
        checkValue({tag, "_tmr128"}, tmr_a, tmr_exp);
        checkValue({tag, "_cnt4"}, count_b, m_cnt[1]);
        checkValue({tag, "_done4"}, done_b, (m_in[1] && m_cnt[1] == m_th[1]) ? 1 : 0);
        checkValue({tag, "_rch4"}, reached_b, m_reached[1]);
        checkValue({tag, "_tmr4"}, tmr_b, 0);
    endtask

    initial begin
        int reached_cycles;
        bit r;
        bit e;
        bit c;
        bit l;

        reset    = 1'b1;
        enable   = 1'b0;
        clear    = 1'b0;
        elevrecb = 1'b0;
        m_prev   = 1'b0;
        tmr_exp  = 1'b0;
        for (int i = 0; i < 2; i++) begin
            m_cnt[i]     = 0;
            m_in[i]      = 1'b0;
            m_reached[i] = 1'b0;
        end

        // Vectors for the THRESHOLD=4 instance: clear racing an edge,
        // saturation, leaving bus-off from DONE, and clear from DONE.
        //                 rst en clr lvl cnt done rch
        vecs.push_back('{1, 0, 0, 0, 0, 0, 0});
        vecs.push_back('{0, 1, 0, 0, 0, 0, 0});
        vecs.push_back('{0, 1, 0, 1, 1, 0, 0});
        vecs.push_back('{0, 1, 0, 1, 1, 0, 0});
        vecs.push_back('{0, 1, 0, 0, 1, 0, 0});
        vecs.push_back('{0, 1, 0, 1, 2, 0, 0});
        vecs.push_back('{0, 1, 0, 0, 2, 0, 0});
        vecs.push_back('{0, 1, 0, 1, 3, 0, 0});
        vecs.push_back('{0, 1, 0, 0, 3, 0, 0});
        vecs.push_back('{0, 1, 1, 1, 0, 0, 0});
        vecs.push_back('{0, 1, 0, 0, 0, 0, 0});
        vecs.push_back('{0, 1, 0, 1, 1, 0, 0});
        vecs.push_back('{0, 1, 0, 0, 1, 0, 0});
        vecs.push_back('{0, 1, 0, 1, 2, 0, 0});
        vecs.push_back('{0, 1, 0, 0, 2, 0, 0});
        vecs.push_back('{0, 1, 0, 1, 3, 0, 0});
        vecs.push_back('{0, 1, 0, 0, 3, 0, 0});
        vecs.push_back('{0, 1, 0, 1, 4, 1, 1});
        vecs.push_back('{0, 1, 0, 0, 4, 1, 0});
        vecs.push_back('{0, 1, 0, 1, 4, 1, 0});
        vecs.push_back('{0, 0, 0, 0, 0, 0, 0});
        vecs.push_back('{0, 1, 0, 1, 0, 0, 0});
        vecs.push_back('{0, 1, 0, 0, 0, 0, 0});
        vecs.push_back('{0, 1, 0, 1, 1, 0, 0});
        vecs.push_back('{0, 1, 0, 0, 1, 0, 0});
        vecs.push_back('{0, 1, 0, 1, 2, 0, 0});
        vecs.push_back('{0, 1, 0, 0, 2, 0, 0});
        vecs.push_back('{0, 1, 0, 1, 3, 0, 0});
        vecs.push_back('{0, 1, 0, 0, 3, 0, 0});
        vecs.push_back('{0, 1, 0, 1, 4, 1, 1});
        vecs.push_back('{0, 1, 1, 0, 0, 0, 0});
        vecs.push_back('{0, 1, 0, 1, 1, 0, 0});

        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i].rst, vecs[i].en, vecs[i].clr, vecs[i].lvl);
            checkValue($sformatf("vec%0d_cnt", i), count_b, vecs[i].cnt);
            checkValue($sformatf("vec%0d_done", i), done_b, vecs[i].done);
            checkValue($sformatf("vec%0d_rch", i), reached_b, vecs[i].rch);
            checkOutput($sformatf("vec%0d", i));
        end

        // Default threshold: 128 pulses, three cycles high and two low.
        applyStimulus(1, 0, 0, 0);
        checkValue("rst_cnt", count_a, 0);
        checkValue("rst_done", done_a, 0);
        checkValue("rst_rch", reached_a, 0);
        checkValue("rst_tmr", tmr_a, 0);
        applyStimulus(0, 1, 0, 0);
        checkOutput("thr_en");
        reached_cycles = 0;
        for (int p = 1; p <= 128; p++) begin
            for (int k = 0; k < 3; k++) begin
                applyStimulus(0, 1, 0, 1);
                checkOutput("thr_hi");
                reached_cycles += int'(reached_a);
                if (k == 0) begin
                    checkValue("thr_edge_cnt", count_a, p);
                    checkValue("thr_edge_done", done_a, (p == 128) ? 1 : 0);
                    checkValue("thr_edge_rch", reached_a, (p == 128) ? 1 : 0);
                end
            end
            for (int k = 0; k < 2; k++) begin
                applyStimulus(0, 1, 0, 0);
                checkOutput("thr_lo");
                reached_cycles += int'(reached_a);
            end
        end
        checkValue("thr_rch_cycles", reached_cycles, 1);
        for (int k = 0; k < 3; k++) begin
            applyStimulus(0, 1, 0, 1);
            checkOutput("thr_extra");
        end
        checkValue("thr_sat_cnt", count_a, 128);
        checkValue("thr_sat_done", done_a, 1);

        // Level already high when enable rises must not count.
        applyStimulus(0, 0, 0, 1);
        applyStimulus(0, 0, 0, 1);
        checkOutput("lvl_off");
        for (int k = 0; k < 20; k++) begin
            applyStimulus(0, 1, 0, 1);
            checkOutput("lvl_held");
        end
        checkValue("lvl_held_cnt", count_a, 0);
        applyStimulus(0, 1, 0, 0);
        applyStimulus(0, 1, 0, 1);
        checkValue("lvl_next_edge_cnt", count_a, 1);
        checkOutput("lvl_next_edge");

        // Reset in the middle of a count.
        applyStimulus(1, 0, 0, 0);
        applyStimulus(0, 1, 0, 0);
        for (int p = 0; p < 57; p++) begin
            applyStimulus(0, 1, 0, 1);
            applyStimulus(0, 1, 0, 0);
        end
        checkValue("mid_cnt57", count_a, 57);
        applyStimulus(1, 1, 0, 0);
        checkValue("mid_rst_cnt", count_a, 0);
        checkValue("mid_rst_done", done_a, 0);
        checkValue("mid_rst_rch", reached_a, 0);
        checkValue("mid_rst_tmr", tmr_a, 0);
        checkOutput("mid_rst");
        applyStimulus(0, 1, 0, 0);
        applyStimulus(0, 1, 0, 1);
        checkValue("mid_after_cnt", count_a, 1);
        checkOutput("mid_after");

`ifdef ERB_RECOVERY_TMR_EN
        // Corrupt one count replica for a single cycle.
        applyStimulus(0, 1, 0, 0);
        dut.count_r[1] = 8'd200;
        tmr_exp = 1'b1;
        applyStimulus(0, 1, 0, 0);
        checkOutput("tmr_inj");
        checkValue("tmr_flag", tmr_a, 1);
        checkValue("tmr_cnt", count_a, 1);
        checkValue("tmr_rep0", dut.count_r[0], 1);
        checkValue("tmr_rep1", dut.count_r[1], 1);
        checkValue("tmr_rep2", dut.count_r[2], 1);
        tmr_exp = 1'b0;
        applyStimulus(0, 1, 0, 0);
        checkValue("tmr_flag_fall", tmr_a, 0);
        checkOutput("tmr_after");
`else
        applyStimulus(0, 1, 0, 0);
        checkValue("tmr_tied", tmr_a, 0);
`endif

        // Randomised traffic against the model.
        for (int n = 0; n < 3000; n++) begin
            r = ($urandom_range(63) == 0);
            e = ($urandom_range(9) != 0);
            c = ($urandom_range(19) == 0);
            l = 1'($urandom_range(1));
            applyStimulus(r, e, c, l);
            checkOutput("rnd");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_erb_recovery_counter

// File: doc/erb_recovery_counter.md
# erb_recovery_counter

Parametrised bus-off recovery counter for the CAN fault-confinement path. It counts rising edges of the MAC FSM's "eleven recessive bits received" strobe while the fault FSM holds the node in bus-off. When a configurable threshold is reached (CAN default 128), it raises a level and a one-cycle pulse. It replaces the fixed 128-count block and adds an enable, a synchronous clear, a saturating done state, a visible count and optional internal triple-modular redundancy (TMR).

## Interface
- THRESHOLD, 128: number of elevrecb rising edges that completes recovery; legal range 1..65535
- CW, $clog2(THRESHOLD+1): count width; derived, never overridden
- clock  in  1  single system clock; all logic on rising edge
- reset  in  1  synchronous, active-high reset
- enable  in  1  fault FSM: node is in bus-off, counting permitted
- clear  in  1  fault FSM: restart count from zero (synchronous, single-cycle or held)
- elevrecb  in  1  MAC FSM: eleven consecutive recessive bits sampled (level, may stay high several cycles)
- erb_count  out  CW  current count, 0..THRESHOLD
- erb_done  out  1  level, count == THRESHOLD
- erb_reached  out  1  one-cycle pulse on entry to DONE
- tmr_error  out  1  registered flag, any replica disagreement seen in the previous cycle

## Operation
- Edge detection: register edged follows elevrecb every cycle in every state, including IDLE. An increment event is elevrecb=1 while edged=0. A level already high when enable rises does not count.
- The FSM has three states in erb_pkg: IDLE, COUNT and DONE.
- IDLE: count held at 0. enable=1 moves to COUNT. An increment event in that same cycle is not counted.
- COUNT: each increment event adds 1. When the increment makes count == THRESHOLD, the FSM goes to DONE. enable=0 goes to IDLE and clears count to 0.
- DONE: count frozen at THRESHOLD; further events ignored. enable=0 goes to IDLE with count 0. clear=1 goes to COUNT with count 0.
- Priority: reset > enable=0 > clear > increment. clear and an increment event in the same cycle give count 0; the event is lost.
- THRESHOLD=1: the first event goes COUNT to DONE directly.
- Arithmetic is unsigned CW-bit. The count never exceeds THRESHOLD and never wraps.
- erb_done = (state == DONE). erb_reached = 1 only in the first cycle the state is DONE.

## Timing
- Reset values: state IDLE, edged 0, erb_count 0, erb_done 0, erb_reached 0, tmr_error 0.
- Latency: an event sampled in cycle N is visible on erb_count in cycle N+1.
- If that event reaches THRESHOLD, erb_done and erb_reached both rise in N+1. erb_reached falls in N+2.
- clear or enable=0 sampled in cycle N gives erb_count 0 and erb_done 0 in N+1.
- Reset mid-count gives every output at its reset value on the next edge; no partial state survives.
- All outputs are driven from registers or decoded from the state register only. There is no combinational path from inputs to outputs.

## Configuration
- Macro: ERB_RECOVERY_TMR_EN.
- Defined:
  - state, edged and count are each held in three replicas.
  - Every register update uses the majority-voted value, so a single upset is scrubbed within one cycle.
  - tmr_error is set for one cycle after any replica mismatch.
- Undefined: single copy of each register; tmr_error tied 0. Port list is identical in both builds.

## Structure
- erb_pkg holds:
  - the state enum erb_state_t, encoded IDLE=2'b00, COUNT=2'b01, DONE=2'b10
  - the default THRESHOLD constant ERB_CAN_THRESHOLD=128
- The illegal state encoding 2'b11 recovers to IDLE on the next edge.
- Sub-module erb_majority_voter, parametrised in width, returns the voted word and a mismatch bit. It is instantiated only when ERB_RECOVERY_TMR_EN is defined.

## Test plan
- Default threshold: reset, then enable=1, then 128 elevrecb pulses of 3 cycles each. Required response:
  - erb_count reaches 128
  - erb_done rises the cycle after the 128th rising edge
  - erb_reached is high for exactly 1 cycle
  - a 129th pulse leaves the count at 128
- Level held across enable: elevrecb=1 held while enable goes 0→1, then elevrecb held high 20 cycles → erb_count stays 0. The next rising edge gives erb_count=1.
- Clear during counting: THRESHOLD=4, count at 3, clear and an elevrecb rising edge in the same cycle → erb_count=0 and erb_done=0 next cycle. Four more edges give erb_done=1.
- Leave bus-off from DONE: enable dropped to 0 while in DONE → next cycle erb_count=0, erb_done=0, state IDLE. Re-enable and count again to THRESHOLD, with the pulse occurring again.
- Reset mid-count: reset=1 at count 57 → all outputs at reset values the following cycle. Release reset with enable=1 and apply one edge → erb_count=1.
- TMR build, ERB_RECOVERY_TMR_EN defined: force one count replica to a wrong value for 1 cycle → tmr_error=1 for one cycle, erb_count unaffected, all replicas equal afterward. In the non-TMR build tmr_error is constantly 0.
